inst_fetch_queue: RTL and testbench

//  Instruction fetch stage that sits directly upstream of the single-cycle 16-bit CPU decode/execute datapath.

---
 rtl/inst_fetch_queue.sv | 90 +++++++++
 tb/tb_inst_fetch_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, requests words from a 1-cycle-latency
// instruction memory and buffers {instr, pc} pairs in a show-ahead FIFO for decode.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [15:0]              imem_addr,
    input  logic [15:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [15:0]              instr_out,
    output logic [15:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_fetch_pc;
    logic [15:0]   r_rsp_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [15:0]   r_buf_instr [DEPTH];
    logic [15:0]   r_buf_pc    [DEPTH];

    logic [CW-1:0] w_credit;
    logic          w_req;
    logic          w_push;
    logic          w_pop;

    // Handshake: the head transfers on a cycle where instr_valid && instr_ready, and
    // instr_valid never depends on instr_ready. A redirect in that cycle cancels the pop.
    // Credit counts in-flight requests as occupied, so a push never meets a full FIFO.
    assign w_credit = r_count + CW'(r_inflight);
    assign w_req    = !reset && !redirect && (w_credit < CW'(DEPTH));
    assign w_push   = r_inflight && !redirect && !reset;
    assign w_pop    = instr_valid && instr_ready && !redirect;

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr_out   = instr_valid ? r_buf_instr[r_rd_ptr] : 16'h0000;
    assign instr_pc    = instr_valid ? r_buf_pc[r_rd_ptr]    : 16'h0000;
    assign count       = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & 16'hFFFE;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + 16'd2;
            end
            r_inflight <= w_req;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Data path carries no reset; validity is tracked entirely by the control state above.
    always_ff @(posedge clock) begin
        if (w_req) begin
            r_rsp_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]    <= r_rsp_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, checked each
// cycle against a queue-based model of the fetch stream.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] WRAP_PC  = 16'hFFFC;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  count;

    logic        req_w;
    logic [15:0] addr_w;
    logic [15:0] rdata_w;
    logic        valid_w;
    logic [15:0] instr_w;
    logic [15:0] pc_w;
    logic [2:0]  count_w;

    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents as {pc, instr}, one pending request, next PC.
    logic [31:0] exp_q[$];
    bit          m_pend;
    logic [15:0] m_pend_pc;
    logic [15:0] m_pc;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .count(count)
    );

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clock(clock), .reset(reset), .imem_req(req_w), .imem_addr(addr_w),
        .imem_rdata(rdata_w), .instr_valid(valid_w), .instr_out(instr_w),
        .instr_pc(pc_w), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_pc(16'h0000), .count(count_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory: word index is addr>>1, data returned the following cycle.
    always @(posedge clock) begin
        imem_rdata <= mem[imem_addr[15:1]];
        rdata_w    <= mem[addr_w[15:1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input logic rst, input logic rd, input logic [15:0] rpc, input logic rdy);
        logic        m_valid;
        logic        m_req;
        logic [31:0] head;
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        m_valid = (exp_q.size() != 0);
        head    = m_valid ? exp_q[0] : 32'h0;
        m_req   = !rst && !rd && ((exp_q.size() + int'(m_pend)) < DEPTH);
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
        chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        chk("instr_out", {16'h0, instr_out}, {16'h0, head[15:0]});
        chk("instr_pc", {16'h0, instr_pc}, {16'h0, head[31:16]});
        chk("count", {29'h0, count}, 32'(exp_q.size()));
        if (rst) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_pc   = RESET_PC;
        end else if (rd) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_pc   = rpc & 16'hFFFE;
        end else begin
            if (m_valid && rdy) void'(exp_q.pop_front());
            if (m_pend) exp_q.push_back({m_pend_pc, mem[m_pend_pc[15:1]]});
            m_pend = m_req;
            if (m_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 16'd2;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] wpc;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h710F;
        mem[1] = 16'h7207;
        mem[2] = 16'h2460;

        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; instr_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        exp_q.delete(); m_pend = 1'b0; m_pc = RESET_PC; m_pend_pc = 16'h0;
        step(1'b1, 1'b0, 16'h0, 1'b1);

        // Back-to-back fetch; the wrap instance runs from FFFC alongside.
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                wpc = WRAP_PC + 16'(2 * (k - 2));
                chk("wrap_valid", {31'h0, valid_w}, 32'h1);
                chk("wrap_pc", {16'h0, pc_w}, {16'h0, wpc});
                chk("wrap_instr", {16'h0, instr_w}, {16'h0, mem[wpc[15:1]]});
            end
            step(1'b0, 1'b0, 16'h0, 1'b1);
        end

        // Stall from reset: FIFO fills to DEPTH and requests stop.
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("stall_count", {29'h0, count}, 32'd4);
        chk("stall_head", {16'h0, instr_out}, 32'h710F);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect while three entries are queued and one is in flight.
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("pre_redirect_count", {29'h0, count}, 32'd3);
        step(1'b0, 1'b1, 16'h0011, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect coinciding with a pop and an arriving response.
        chk("pre_flush_valid", {31'h0, instr_valid}, 32'h1);
        step(1'b0, 1'b1, 16'h4A37, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Reset pulse with two entries queued and a response in flight.
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'h0, 1'b1);

        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
